apb_regspace_bridge: RTL and testbench
======================================

// Module: apb_regspace_bridge
// PURPOSE
//  APB3 slave front end for a RegSpaceBase register block: converts one APB transfer into
//  one downstream rreq/rack (read) or wreq (write) handshake and returns the result to APB.
//  Sits between the system APB interconnect and the register space; one transfer at a time.
//  Unanswered requests time out; misaligned accesses are rejected; both return PSLVERR.
// PARAMETERS
//  ADDR_W   16   APB and register-space byte address width
//  DATA_W   32   data width (fixed 32; byte lanes not supported)
//  TIMEOUT  64   cycles a downstream handshake may stall before abort (>=2)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  psel       in   1       APB select
//  penable    in   1       APB access phase
//  pwrite     in   1       1=write, 0=read
//  paddr      in   ADDR_W  APB byte address
//  pwdata     in   DATA_W  APB write data
//  pready     out  1       transfer complete
//  prdata     out  DATA_W  read data, valid with pready on a read
//  pslverr    out  1       error response, valid with pready
//  rreq_addr  out  ADDR_W  read request address
//  rreq_vld   out  1       read request valid
//  rreq_rdy   in   1       read request accepted
//  rack_data  in   DATA_W  read return data
//  rack_vld   in   1       read return valid
//  rack_rdy   out  1       bridge accepts read return
//  wreq_addr  out  ADDR_W  write request address
//  wreq_data  out  DATA_W  write request data
//  wreq_vld   out  1       write request valid
//  wreq_rdy   in   1       write request accepted
//  err_cnt    out  8       saturating count of PSLVERR responses since reset
// BEHAVIOUR
//  Reset: state IDLE; pready, pslverr, rreq_vld, rack_rdy, wreq_vld = 0; prdata, addr/data regs,
//   err_cnt, timeout counter = 0. Reset mid-transfer drops it; no downstream handshake follows.
//  States: IDLE, WR, RD, DONE. All downstream outputs and pready/pslverr/prdata are flops.
//  IDLE: on psel & !penable (setup) latch paddr, pwdata, pwrite; if paddr[1:0]!=0 -> DONE with
//   err=1, no downstream access; else pwrite ? WR : RD. penable without prior setup is ignored.
//  WR: wreq_vld=1, wreq_addr/wreq_data = latched values. wreq_vld & wreq_rdy -> DONE, err=0.
//  RD: rreq_vld=1 and rack_rdy=1 together, rreq_addr = latched addr. Req-accepted and
//   ack-received tracked independently (may occur same cycle, either order). rreq_vld drops the
//   cycle after rreq_rdy seen; rack_rdy stays 1 until rack_vld seen. On rack_vld & rack_rdy
//   capture rack_data into prdata. Both seen -> DONE, err=0.
//  Timeout: counter clears on entry to WR/RD, increments each cycle there; at TIMEOUT-1 without
//   completion: drop all vld/rdy, DONE with err=1, prdata=0. Completion on that same cycle wins.
//  DONE: pready=1, pslverr=err for exactly one cycle, then IDLE. prdata=0 on writes and errors.
//   psel/penable are not re-checked in WR/RD/DONE (APB master must hold them, per protocol).
//  Latency: zero-wait downstream -> setup T0, WR/RD T1, pready T2 (one APB wait state min).
//  err_cnt: +1 on every DONE cycle with err=1; saturates at 255; cleared only by reset.
//  Only one outstanding transfer; new setup accepted only in IDLE.
// TESTING
//  Write 0x20=0xA5A5_0001, wreq_rdy=1 -> wreq_vld 1 cycle with addr 0x20, pready at T2, pslverr=0.
//  Read 0x0, rreq_rdy & rack_vld=1 same cycle, rack_data=0x1234_5678 -> prdata=0x12345678 at T2.
//  Read with rreq_rdy at T1, rack_vld at T4 -> rreq_vld low from T2, rack_rdy high to T4, pready T5.
//  Write, wreq_rdy held 0 -> pready=1, pslverr=1 at cycle T1+TIMEOUT, err_cnt=1.
//  Read paddr=0x22 -> no rreq_vld, pready=1 pslverr=1 prdata=0 at T1; 256 such -> err_cnt=255.
//  rst=1 during RD wait -> next cycle rreq_vld=rack_rdy=pready=0, state IDLE, next APB read works.

Source files
------------

// File: rtl/apb_regspace_bridge.sv
// apb_regspace_bridge
//   APB3 slave front end for a register space. Each APB transfer becomes exactly
//   one downstream write request (wreq) or one read request/acknowledge pair
//   (rreq/rack). The result is returned on pready/prdata/pslverr. Only one
//   transfer is handled at a time. A stalled downstream handshake aborts after
//   TIMEOUT cycles, and a misaligned address is rejected without any downstream
//   access. Both cases complete with pslverr=1.
//
//   Ports:
//     clk, rst                       clock; synchronous active-high reset
//     psel, penable, pwrite,
//     paddr, pwdata                  APB request side
//     pready, prdata, pslverr        APB response (registered)
//     rreq_addr/vld/rdy              downstream read request
//     rack_data/vld/rdy              downstream read return
//     wreq_addr/data/vld/rdy         downstream write request
//     err_cnt                        saturating count of error responses
module apb_regspace_bridge #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic [ADDR_W-1:0] rreq_addr,
    output logic              rreq_vld,
    input  logic              rreq_rdy,
    input  logic [DATA_W-1:0] rack_data,
    input  logic              rack_vld,
    output logic              rack_rdy,
    output logic [ADDR_W-1:0] wreq_addr,
    output logic [DATA_W-1:0] wreq_data,
    output logic              wreq_vld,
    input  logic              wreq_rdy,
    output logic [7:0]        err_cnt
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              rreq_vld_q, rreq_vld_d;
    logic              rack_rdy_q, rack_rdy_d;
    logic              wreq_vld_q, wreq_vld_d;
    logic              req_seen_q, req_seen_d;
    logic              ack_seen_q, ack_seen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              req_now, ack_now, at_limit;

    assign at_limit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        prdata_d   = prdata_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        rreq_vld_d = rreq_vld_q;
        rack_rdy_d = rack_rdy_q;
        wreq_vld_d = wreq_vld_q;
        req_seen_d = req_seen_q;
        ack_seen_d = ack_seen_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;
        // Request acceptance and read return are tracked independently;
        // either may arrive first or both in the same cycle.
        req_now    = req_seen_q | (rreq_vld_q & rreq_rdy);
        ack_now    = ack_seen_q | (rack_vld & rack_rdy_q);

        if (state_q == DONE && pslverr_q && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d   = paddr;
                    wdata_d  = pwdata;
                    prdata_d = '0;
                    cnt_d    = '0;
                    if (paddr[1:0] != 2'b00) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (pwrite) begin
                        state_d    = WR;
                        wreq_vld_d = 1'b1;
                    end else begin
                        state_d    = RD;
                        rreq_vld_d = 1'b1;
                        rack_rdy_d = 1'b1;
                        req_seen_d = 1'b0;
                        ack_seen_d = 1'b0;
                    end
                end
            end
            WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wreq_vld_q && wreq_rdy) begin
                    wreq_vld_d = 1'b0;
                    state_d    = DONE;
                    pready_d   = 1'b1;
                end else if (at_limit) begin
                    wreq_vld_d = 1'b0;
                    state_d    = DONE;
                    pready_d   = 1'b1;
                    pslverr_d  = 1'b1;
                    prdata_d   = '0;
                end
            end
            RD: begin
                cnt_d      = cnt_q + CNT_W'(1);
                req_seen_d = req_now;
                ack_seen_d = ack_now;
                rreq_vld_d = !req_now;
                rack_rdy_d = !ack_now;
                if (rack_vld && rack_rdy_q) begin
                    prdata_d = rack_data;
                end
                // Completion in the final allowed cycle takes priority over the abort.
                if (req_now && ack_now) begin
                    state_d  = DONE;
                    pready_d = 1'b1;
                end else if (at_limit) begin
                    rreq_vld_d = 1'b0;
                    rack_rdy_d = 1'b0;
                    state_d    = DONE;
                    pready_d   = 1'b1;
                    pslverr_d  = 1'b1;
                    prdata_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            rreq_vld_q <= 1'b0;
            rack_rdy_q <= 1'b0;
            wreq_vld_q <= 1'b0;
            req_seen_q <= 1'b0;
            ack_seen_q <= 1'b0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            rreq_vld_q <= rreq_vld_d;
            rack_rdy_q <= rack_rdy_d;
            wreq_vld_q <= wreq_vld_d;
            req_seen_q <= req_seen_d;
            ack_seen_q <= ack_seen_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign pready    = pready_q;
    assign prdata    = prdata_q;
    assign pslverr   = pslverr_q;
    assign rreq_addr = addr_q;
    assign rreq_vld  = rreq_vld_q;
    assign rack_rdy  = rack_rdy_q;
    assign wreq_addr = addr_q;
    assign wreq_data = wdata_q;
    assign wreq_vld  = wreq_vld_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb_regspace_bridge.sv
// tb_apb_regspace_bridge
//   Drives APB transfers with random addresses, data and downstream stall
//   patterns. A word-addressed memory stub answers downstream requests.
//   Expected latency, error, read data and error count come from a
//   transfer-level reference model kept here.
module tb_apb_regspace_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [15:0] rreq_addr, wreq_addr;
    logic        rreq_vld, rack_rdy, wreq_vld;
    logic        rreq_rdy = 1'b0, rack_vld = 1'b0, wreq_rdy = 1'b0;
    logic [31:0] rack_data, wreq_data;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Device-side stub memory, plus the model's own view of the register space.
    logic [31:0] dev_mem  [256];
    logic [31:0] seed_mem [256];
    logic [31:0] ref_mem  [256];
    logic        load_mem = 1'b0;
    int          wr_hs = 0;
    int          rd_hs = 0;
    int          ref_err = 0;

    always #5 clk = ~clk;

    apb_regspace_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .rreq_addr(rreq_addr), .rreq_vld(rreq_vld), .rreq_rdy(rreq_rdy),
        .rack_data(rack_data), .rack_vld(rack_vld), .rack_rdy(rack_rdy),
        .wreq_addr(wreq_addr), .wreq_data(wreq_data), .wreq_vld(wreq_vld), .wreq_rdy(wreq_rdy),
        .err_cnt(err_cnt)
    );

    assign rack_data = dev_mem[rreq_addr[9:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            dev_mem <= seed_mem;
        end else if (wreq_vld && wreq_rdy) begin
            dev_mem[wreq_addr[9:2]] <= wreq_data;
        end
        if (wreq_vld && wreq_rdy) wr_hs <= wr_hs + 1;
        if (rreq_vld && rreq_rdy) rd_hs <= rd_hs + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 11));
        if (r == 0) return TO - 1;
        if (r == 1) return TO + int'($urandom_range(0, 5));
        return int'($urandom_range(0, 4));
    endfunction

    // One complete APB transfer. dw/dr/da: cycles after the first access-phase
    // cycle before wreq_rdy / rreq_rdy / rack_vld rise (then held).
    task automatic do_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                           input int dw, input int dr, input int da);
        bit          mis, exp_err, rd_ok;
        int          m, exp_lat, lat, k, wr0, rd0;
        logic [31:0] exp_rd;
        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else begin
            m = wr ? dw : ((dr > da) ? dr : da);
            if (m <= TO - 1) begin
                exp_lat = m + 2;
                exp_err = 1'b0;
            end else begin
                exp_lat = TO + 1;
                exp_err = 1'b1;
            end
        end
        rd_ok  = !wr && !mis && !exp_err;
        exp_rd = rd_ok ? ref_mem[addr[9:2]] : 32'h0;
        wr0 = wr_hs;
        rd0 = rd_hs;

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        wreq_rdy = 1'b0; rreq_rdy = 1'b0; rack_vld = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        for (int cyc = 1; cyc <= TO + 4; cyc++) begin
            k = cyc - 1;
            wreq_rdy = wr && (k >= dw);
            rreq_rdy = !wr && (k >= dr);
            rack_vld = !wr && (k >= da);
            if (pready) begin
                lat = cyc;
                break;
            end
            if (cyc == 1 && !mis) begin
                if (wr) begin
                    check_eq("wreq_addr", 32'(wreq_addr), 32'(addr));
                    check_eq("wreq_data", wreq_data, data);
                end else begin
                    check_eq("rreq_addr", 32'(rreq_addr), 32'(addr));
                end
            end
            if (cyc < exp_lat) begin
                check_eq("wreq_vld_busy", 32'(wreq_vld), 32'(wr && !mis));
                check_eq("rreq_vld_busy", 32'(rreq_vld), 32'(!wr && !mis && k <= dr));
                check_eq("rack_rdy_busy", 32'(rack_rdy), 32'(!wr && !mis && k <= da));
            end
            @(posedge clk); #1;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        if (lat != 0) begin
            check_eq("pslverr", 32'(pslverr), 32'(exp_err));
            check_eq("prdata", prdata, exp_rd);
            check_eq("vld_done", 32'({wreq_vld, rreq_vld, rack_rdy}), 32'h0);
        end
        psel = 1'b0; penable = 1'b0;
        wreq_rdy = 1'b0; rreq_rdy = 1'b0; rack_vld = 1'b0;

        if (wr && !mis && !exp_err) ref_mem[addr[9:2]] = data;
        if (exp_err && ref_err < 255) ref_err++;

        @(posedge clk); #1;
        check_eq("pready_one_cycle", 32'(pready), 32'h0);
        check_eq("err_cnt", 32'(err_cnt), 32'(ref_err));
        check_eq("wr_handshakes", 32'(wr_hs - wr0), 32'(wr && !mis && !exp_err));
        check_eq("rd_handshakes", 32'(rd_hs - rd0), 32'(!wr && !mis && dr <= TO - 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [15:0] a;
        bit          w;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            seed_mem[i] = v;
            ref_mem[i]  = v;
        end
        seed_mem[0] = 32'h1234_5678;
        ref_mem[0]  = 32'h1234_5678;
        load_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        rst = 1'b0;

        check_eq("rst_pready", 32'(pready), 32'h0);
        check_eq("rst_pslverr", 32'(pslverr), 32'h0);
        check_eq("rst_prdata", prdata, 32'h0);
        check_eq("rst_vld", 32'({wreq_vld, rreq_vld, rack_rdy}), 32'h0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);

        do_xfer(1'b1, 16'h0020, 32'hA5A5_0001, 0, 0, 0);
        do_xfer(1'b0, 16'h0000, 32'h0, 0, 0, 0);
        do_xfer(1'b0, 16'h0020, 32'h0, 0, 0, 0);
        do_xfer(1'b0, 16'h0008, 32'h0, 0, 0, 3);
        do_xfer(1'b0, 16'h000C, 32'h0, 3, 0, 0);
        do_xfer(1'b1, 16'h0030, 32'hDEAD_BEEF, 1000, 0, 0);
        do_xfer(1'b0, 16'h0022, 32'h0, 0, 0, 0);
        do_xfer(1'b1, 16'h0034, 32'h0BAD_F00D, TO - 1, 0, 0);
        do_xfer(1'b0, 16'h0034, 32'h0, TO - 1, 2, TO - 1);
        do_xfer(1'b0, 16'h0038, 32'h0, 0, 1, TO);
        do_xfer(1'b0, 16'h003C, 32'h0, 0, TO, 0);

        for (int n = 0; n < 200; n++) begin
            w = 1'(($urandom_range(0, 1)));
            a = {6'b0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_xfer(w, a, $urandom, rand_delay(), rand_delay(), rand_delay());
        end

        // Reset while a read waits on a stalled downstream.
        begin
            int rd0;
            rd0 = rd_hs;
            psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0040;
            @(posedge clk); #1;
            penable = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; psel = 1'b0; penable = 1'b0;
            ref_err = 0;
            check_eq("midrst_vld", 32'({rreq_vld, rack_rdy}), 32'h0);
            check_eq("midrst_pready", 32'(pready), 32'h0);
            check_eq("midrst_err_cnt", 32'(err_cnt), 32'h0);
            @(posedge clk); #1;
            check_eq("midrst_idle", 32'({pready, rreq_vld, rack_rdy}), 32'h0);
            check_eq("midrst_no_hs", 32'(rd_hs - rd0), 32'h0);
            do_xfer(1'b0, 16'h0040, 32'h0, 0, 1, 2);
        end

        // Error counter saturation.
        for (int n = 0; n < 260; n++) begin
            a = {8'h00, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            do_xfer(1'($urandom_range(0, 1)), a, $urandom, 0, 0, 0);
        end
        check_eq("err_cnt_saturated", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
